// File: rtl/ecc_pkg.sv
// Shared constants for the sect233 point-multiply datapath and its controllers.
package ecc_pkg;

    localparam int KEY_W  = 233;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 8;

    // key_cnt value once every scalar bit has been consumed, and the value one short of it
    localparam logic [CNT_W-1:0] KEY_CNT_MAX  = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] KEY_CNT_LAST = CNT_W'(KEY_W - 1);

    // key_state encodings, also decoded by the PM controller
    localparam logic [1:0] KEY_UNKNOWN = 2'b00;
    localparam logic [1:0] KEY_IS_ZERO = 2'b01;
    localparam logic [1:0] KEY_IS_ONE  = 2'b11;
    localparam logic [1:0] KEY_NORMAL  = 2'b10;

    typedef enum logic [2:0] {
        SCAN_IDLE,
        SCAN_LOAD,
        SCAN_CHECK,
        SCAN_CHK_DONE,
        SCAN_SEARCH,
        SCAN_READY,
        SCAN_SHIFT,
        SCAN_DONE
    } scan_state_t;

    function automatic logic [1:0] classify_key(input logic is_zero, input logic is_one);
        if (is_zero)
            return KEY_IS_ZERO;
        else if (is_one)
            return KEY_IS_ONE;
        else
            return KEY_NORMAL;
    endfunction

endpackage

// File: rtl/key_shift_reg.sv
// 233-bit working copy of the scalar; shifts left so the next key bit is always at msb.
import ecc_pkg::*;

module key_shift_reg (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic [KEY_W-1:0] d,
    output logic             msb,
    output logic             is_zero,
    output logic             is_one
);

    logic [KEY_W-1:0] sr;

    // load has priority; shifting pulls zeros in at the LSB
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            sr <= '0;
        else if (load)
            sr <= d;
        else if (shift)
            sr <= {sr[KEY_W-2:0], 1'b0};
    end

    assign msb     = sr[KEY_W-1];
    assign is_zero = (sr == '0);
    assign is_one  = (sr == KEY_W'(1));

endmodule

// File: rtl/key_scanner.sv
// Key-bit supplier for the Montgomery-ladder controller: loads, classifies and
// scans the scalar MSB-first, starting after its leading one.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | key in sr, waiting for key_check or find_key_first
// LOAD      | words shifting into staging register, outputs cleared
// CHECK     | registering key_state from sr
// CHK_DONE  | key_state valid, waiting for find_key_first
// SEARCH    | one sr bit per cycle until the leading one is seen
// READY     | waiting for keyscan_en
// SHIFT     | presenting the next key bit on ki
// DONE      | key exhausted, outputs frozen until key_load
import ecc_pkg::*;

module key_scanner (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] KEY_IN,
    input  logic              key_load,
    input  logic              key_check,
    input  logic              find_key_first,
    input  logic              keyscan_en,
    output logic              ki,
    output logic              key_first_found,
    output logic [CNT_W-1:0]  key_cnt,
    output logic [1:0]        key_state
);

    scan_state_t state, state_nxt;

    // Only stage[232:0] is ever observed, and bits above that are simply pushed
    // out by later words, so the staging register stops at the key width.
    logic [KEY_W-1:0] stage;

    logic sr_load, sr_shift;
    logic sr_msb, sr_is_zero, sr_is_one;
    logic clr_out, cnt_inc, set_found, take_ki, take_class;
    logic search_ok;

    key_shift_reg u_sr (
        .CLK     (CLK),
        .RST     (RST),
        .load    (sr_load),
        .shift   (sr_shift),
        .d       (stage),
        .msb     (sr_msb),
        .is_zero (sr_is_zero),
        .is_one  (sr_is_one)
    );

    // zero and one keys have no ladder to run, so searching them is refused
    assign search_ok = (key_state != KEY_IS_ZERO) && (key_state != KEY_IS_ONE);

    // staging register: most-significant word arrives first
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stage <= '0;
        else if (key_load)
            stage <= {stage[KEY_W-WORD_W-1:0], KEY_IN};
    end

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= SCAN_IDLE;
        else
            state <= state_nxt;
    end

    // next-state and datapath controls; key_load overrides everything
    always_comb begin
        state_nxt  = state;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        clr_out    = 1'b0;
        cnt_inc    = 1'b0;
        set_found  = 1'b0;
        take_ki    = 1'b0;
        take_class = 1'b0;
        if (key_load) begin
            state_nxt = SCAN_LOAD;
            clr_out   = 1'b1;
        end else begin
            case (state)
                SCAN_LOAD: begin
                    clr_out   = 1'b1;
                    sr_load   = 1'b1;
                    state_nxt = SCAN_IDLE;
                end
                SCAN_IDLE: begin
                    if (key_check)
                        state_nxt = SCAN_CHECK;
                    else if (find_key_first && search_ok)
                        state_nxt = SCAN_SEARCH;
                end
                SCAN_CHECK: begin
                    take_class = 1'b1;
                    state_nxt  = SCAN_CHK_DONE;
                end
                SCAN_CHK_DONE: begin
                    if (find_key_first && search_ok)
                        state_nxt = SCAN_SEARCH;
                end
                SCAN_SEARCH: begin
                    sr_shift = 1'b1;
                    cnt_inc  = 1'b1;
                    if (sr_msb) begin
                        set_found = 1'b1;
                        state_nxt = SCAN_READY;
                    end else if (key_cnt == KEY_CNT_LAST) begin
                        state_nxt = SCAN_DONE;
                    end
                end
                SCAN_READY: begin
                    if (keyscan_en) begin
                        if (key_cnt < KEY_CNT_MAX)
                            state_nxt = SCAN_SHIFT;
                        else
                            state_nxt = SCAN_DONE;
                    end
                end
                SCAN_SHIFT: begin
                    sr_shift  = 1'b1;
                    cnt_inc   = 1'b1;
                    take_ki   = 1'b1;
                    state_nxt = SCAN_READY;
                end
                SCAN_DONE: begin
                    state_nxt = SCAN_DONE;
                end
            endcase
        end
    end

    // output registers; ki and key_cnt hold between shifts
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ki              <= 1'b0;
            key_first_found <= 1'b0;
            key_cnt         <= '0;
            key_state       <= KEY_UNKNOWN;
        end else if (clr_out) begin
            ki              <= 1'b0;
            key_first_found <= 1'b0;
            key_cnt         <= '0;
            key_state       <= KEY_UNKNOWN;
        end else begin
            if (cnt_inc)
                key_cnt <= key_cnt + 8'd1;
            if (set_found)
                key_first_found <= 1'b1;
            if (take_ki)
                ki <= sr_msb;
            if (take_class)
                key_state <= classify_key(sr_is_zero, sr_is_one);
        end
    end

endmodule
